rl_ram_1r1w_gen: RTL

//  Technology-independent, parametrised 1R1W RAM. Next generation of the per-vendor 1R1W wrappers.

---
 rtl/rl_ram_pkg.sv | 32 +++
 rtl/rl_ram_1r1w_core.sv | 59 +++++
 rtl/rl_ram_1r1w_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rl_ram_pkg.sv
// Shared types and helpers for the generic 1R1W RAM family.
package rl_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_t;

  // Upper bound on the data width the parity helper can handle.
  localparam int MAX_DBITS = 1024;
  localparam int MAX_BYTES = MAX_DBITS / 8;

  // Number of byte lanes needed to cover dbits (last lane may be partial).
  function automatic int bytes(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  // Even-parity bit per byte lane; lanes with be=0 report 0.
  // Callers zero-extend their data so a partial last lane stays correct.
  function automatic logic [MAX_BYTES-1:0] lane_parity(
    input logic [MAX_DBITS-1:0] data,
    input logic [MAX_BYTES-1:0] be
  );
    logic [MAX_BYTES-1:0] par;
    par = '0;
    for (int n = 0; n < MAX_BYTES; n++) begin
      par[n] = be[n] & (^data[8*n +: 8]);
    end
    return par;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w_core.sv
// Behavioural 1R1W storage array: byte-lane write port, registered read port.
// Bits [DBITS-1:0] are data (lane = bit/8); bits above DBITS are one extra
// bit per lane (used for parity) and follow that lane's enable.
module rl_ram_1r1w_core
  import rl_ram_pkg::*;
#(
  parameter  int ABITS = 10,
  parameter  int DBITS = 32,
  parameter  int PBITS = 0,
  localparam int LANES = bytes(DBITS),
  localparam int WBITS = DBITS + PBITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [WBITS-1:0] wdata_i,
  input  logic [LANES-1:0] be_i,
  input  logic             re_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [WBITS-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ABITS;

  logic [WBITS-1:0] mem [DEPTH];
  logic [WBITS-1:0] rdata_q;
  logic [WBITS-1:0] bit_en;

  // Expand lane enables to one enable per stored bit
  for (genvar gi = 0; gi < WBITS; gi++) begin : g_bit_en
    if (gi < DBITS) begin : g_data
      assign bit_en[gi] = be_i[gi / 8];
    end else begin : g_extra
      assign bit_en[gi] = be_i[gi - DBITS];
    end
  end

  // Write only the enabled lanes; other lanes keep their contents
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < WBITS; b++) begin
        if (bit_en[b]) mem[waddr_i][b] <= wdata_i[b];
      end
    end
  end

  // Registered read (returns pre-write data on a same-edge collision)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rl_ram_1r1w_gen.sv
// Generic 1R1W RAM: post-reset clear FSM with ready, read latency 1 or 2 with
// a valid strobe, optional same-address write bypass.
// Optional per-lane parity is enabled by defining RL_RAM_1R1W_PARITY_EN.
module rl_ram_1r1w_gen
  import rl_ram_pkg::*;
#(
  parameter  int ABITS      = 10,
  parameter  int DBITS      = 32,
  parameter  int RD_LATENCY = 1,
  parameter  int INIT_CLEAR = 1,
  parameter  int BYPASS     = 1,
  localparam int BYTES      = bytes(DBITS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             ready_o,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] din_i,
  input  logic             we_i,
  input  logic [BYTES-1:0] be_i,
  input  logic [ABITS-1:0] raddr_i,
  input  logic             re_i,
  output logic [DBITS-1:0] dout_o,
  output logic             dvalid_o,
  output logic [BYTES-1:0] perr_o
);

`ifdef RL_RAM_1R1W_PARITY_EN
  localparam int PBITS = BYTES;
`else
  localparam int PBITS = 0;
`endif
  localparam int WBITS = DBITS + PBITS;

  ram_state_t       state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;
  logic             ready_q;

  logic             mem_we, rd_en;
  logic [ABITS-1:0] mem_waddr;
  logic [DBITS-1:0] mem_wdata;
  logic [BYTES-1:0] mem_be;
  logic [WBITS-1:0] mem_wfull, core_rdata;
  logic [DBITS-1:0] core_data;

  logic             v1_q, byp_hit_q;
  logic [BYTES-1:0] byp_be_q;
  logic [DBITS-1:0] byp_data_q;
  logic [DBITS-1:0] s1_data;
  logic [BYTES-1:0] s1_perr;

  // Clear counter walks every address once, then the FSM settles in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = RUN;
    end
  end

  // FSM state, clear counter and registered ready
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= (INIT_CLEAR != 0) ? INIT : RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  assign ready_o = ready_q;
  assign rd_en   = re_i & ready_q;

  // Write port mux: clear writes during INIT, user writes once ready
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr_i;
    mem_wdata = din_i;
    mem_be    = be_i;
    if (rst_ni) begin
      if (state_q == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
      end else begin
        mem_we = we_i & ready_q;
      end
    end
  end

  rl_ram_1r1w_core #(
    .ABITS (ABITS),
    .DBITS (DBITS),
    .PBITS (PBITS)
  ) u_core (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wfull),
    .be_i    (mem_be),
    .re_i    (rd_en),
    .raddr_i (raddr_i),
    .rdata_o (core_rdata)
  );

  assign core_data = core_rdata[DBITS-1:0];

  // Capture read valid and same-address write info alongside the array read
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q       <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      v1_q <= rd_en;
      if (rd_en) begin
        byp_hit_q  <= (BYPASS != 0) && mem_we && (mem_waddr == raddr_i);
        byp_be_q   <= be_i;
        byp_data_q <= din_i;
      end
    end
  end

  // Bypassed lanes take the colliding write data, others the stored data
  for (genvar gi = 0; gi < DBITS; gi++) begin : g_merge
    assign s1_data[gi] = (byp_hit_q && byp_be_q[gi / 8]) ? byp_data_q[gi] : core_data[gi];
  end

`ifdef RL_RAM_1R1W_PARITY_EN
  logic [MAX_DBITS-1:0] wdata_ext, rdata_ext;
  logic [MAX_BYTES-1:0] wpar_full, rpar_full;
  logic [BYTES-1:0]     core_par;
  logic                 unused_par_hi;

  // Even parity per lane for the write path and for the read check
  always_comb begin
    wdata_ext = '0;
    wdata_ext[DBITS-1:0] = mem_wdata;
    rdata_ext = '0;
    rdata_ext[DBITS-1:0] = core_data;
    wpar_full = lane_parity(wdata_ext, '1);
    rpar_full = lane_parity(rdata_ext, '1);
  end

  assign unused_par_hi = ^{wpar_full[MAX_BYTES-1:BYTES], rpar_full[MAX_BYTES-1:BYTES]};
  assign mem_wfull     = {wpar_full[BYTES-1:0], mem_wdata};
  assign core_par      = core_rdata[WBITS-1:DBITS];
  // Bypassed lanes did not come from the array, so they never flag
  assign s1_perr = (rpar_full[BYTES-1:0] ^ core_par) & ~(byp_hit_q ? byp_be_q : '0);
`else
  assign mem_wfull = mem_wdata;
  assign s1_perr   = '0;
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DBITS-1:0] dout_q;
    logic [BYTES-1:0] perr_q;
    logic             v2_q;

    // Second output stage; data holds between reads
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        dout_q <= '0;
        perr_q <= '0;
        v2_q   <= 1'b0;
      end else begin
        v2_q   <= v1_q;
        perr_q <= v1_q ? s1_perr : '0;
        if (v1_q) dout_q <= s1_data;
      end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = v2_q;
    assign perr_o   = perr_q;
  end else begin : g_lat1
    assign dout_o   = s1_data;
    assign dvalid_o = v1_q;
    assign perr_o   = v1_q ? s1_perr : '0;
  end

endmodule
